// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants, sync bundle type and a range helper.
package vga_pkg;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FRONT   = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_BACK    = 10'd48;
    localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FRONT   = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BACK    = 10'd33;
    localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] X_BLANK   = 10'h3FF;
    localparam logic [8:0] Y_BLANK   = 9'h1FF;

    // Idle level of the sync bundle: both syncs inactive (high), blanked.
    localparam logic [2:0] SYNC_RST  = 3'b110;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_n;
    } sync_t;

    function automatic logic in_span(input logic [9:0] val,
                                     input logic [9:0] lo,
                                     input logic [9:0] len);
        return (val >= lo) && (val < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth register chain for the {hsync, vsync, blank_n} bundle.
// DEPTH = 0 degenerates to a plain wire.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int         DEPTH   = 2,
    parameter logic [2:0] RST_VAL = SYNC_RST
) (
    input  logic       clk_i,
    input  logic       srst_i,
    input  logic [2:0] data_i,
    output logic [2:0] data_o
);

    if (DEPTH == 0) begin : g_comb
        logic unused_ok;
        assign unused_ok = clk_i ^ srst_i;
        assign data_o    = data_i;
    end else begin : g_chain
        logic [2:0] stage_q [DEPTH];

        // Shifts on every clock so the delay is in clocks, not pixels.
        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q[0] <= data_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign data_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA 640x480 timing generator: pixel/line counters, x/y decode, delayed syncs.
// Define VGA_PIX_DIV2_EN to advance the counters on every other clock.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int SYNC_DELAY = 2
) (
    input  logic       clock,
    input  logic       reset,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       pix_tick,
    output logic       frame_start
);

    logic [9:0] h_cnt_q;
    logic [9:0] h_cnt_d;
    logic [9:0] v_cnt_q;
    logic [9:0] v_cnt_d;
    logic       h_wrap;
    logic       v_wrap;
    sync_t      sync_raw;
    sync_t      sync_dly;

    if (SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_bad_sync_delay
        $error("vga_timing_gen: SYNC_DELAY must be in 0..3");
    end

`ifdef VGA_PIX_DIV2_EN
    logic div_q;

    // First clock after reset is idle, then ticks alternate.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= 1'b0;
        end else begin
            div_q <= ~div_q;
        end
    end

    assign pix_tick = ~reset & div_q;
`else
    assign pix_tick = ~reset;
`endif

    assign h_wrap = (h_cnt_q == H_TOTAL - 10'd1);
    assign v_wrap = (v_cnt_q == V_TOTAL - 10'd1);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_tick) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign frame_start = pix_tick & h_wrap & v_wrap;

    assign x = (h_cnt_q < H_VISIBLE) ? h_cnt_q : X_BLANK;
    assign y = (v_cnt_q < V_VISIBLE) ? v_cnt_q[8:0] : Y_BLANK;

    assign sync_raw.hsync   = ~in_span(h_cnt_q, H_VISIBLE + H_FRONT, H_SYNC);
    assign sync_raw.vsync   = ~in_span(v_cnt_q, V_VISIBLE + V_FRONT, V_SYNC);
    assign sync_raw.blank_n = (h_cnt_q < H_VISIBLE) && (v_cnt_q < V_VISIBLE);

    vga_sync_delay #(
        .DEPTH   (SYNC_DELAY),
        .RST_VAL (SYNC_RST)
    ) u_sync_delay (
        .clk_i  (clock),
        .srst_i (reset),
        .data_i (sync_raw),
        .data_o (sync_dly)
    );

    assign hsync   = sync_dly.hsync;
    assign vsync   = sync_dly.vsync;
    assign blank_n = sync_dly.blank_n;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter SYNC_DELAY, default 2: clock cycles of delay (0..3) applied to hsync/vsync/blank_n so they align with the downstream translator and memory.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port x, output, 10 bits: visible pixel column 0..639, or 10'h3FF while horizontally blanked.
REQ-005 SHALL have port y, output, 9 bits: visible pixel row 0..479, or 9'h1FF while vertically blanked.
REQ-006 SHALL have port hsync, output, 1 bit: active-low horizontal sync, delayed by SYNC_DELAY.
REQ-007 SHALL have port vsync, output, 1 bit: active-low vertical sync, delayed by SYNC_DELAY.
REQ-008 SHALL have port blank_n, output, 1 bit: high in the active 640x480 region, delayed by SYNC_DELAY.
REQ-009 SHALL have port pix_tick, output, 1 bit: high on clocks where the counters advance.
REQ-010 SHALL have port frame_start, output, 1 bit: one-clock pulse on the tick that wraps both counters to 0.

Function
REQ-011 SHALL keep h_cnt (10 bits, 0..799) and v_cnt (10 bits, 0..524) and update them only on pix_tick clocks.
REQ-012 SHALL increment h_cnt on each tick; at 799 h_cnt SHALL wrap to 0 and v_cnt SHALL increment in the same clock.
REQ-013 SHALL wrap v_cnt from 524 to 0 when h_cnt wraps at the same time; no other count values are reachable.
REQ-014 SHALL use horizontal timing visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-015 SHALL use vertical timing visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-016 SHALL decode x and y combinationally from the counters with zero latency: x = h_cnt if h_cnt < 640, else 10'h3FF; y = v_cnt[8:0] if v_cnt < 480, else 9'h1FF.
REQ-017 SHALL decode raw hsync = 0 iff h_cnt is in 656..751, raw vsync = 0 iff v_cnt is in 490..491, and raw blank_n = (h_cnt < 640) && (v_cnt < 480).
REQ-018 SHALL pass the raw hsync, vsync and blank_n through a SYNC_DELAY-stage register chain that shifts every clock, not only on ticks; SYNC_DELAY = 0 SHALL make them combinational.
REQ-019 SHALL assert frame_start combinationally when pix_tick = 1, h_cnt = 799 and v_cnt = 524.
REQ-020 SHALL treat a SYNC_DELAY value outside 0..3 as an elaboration error.

Reset
REQ-021 SHALL, on a clock with reset = 1, set h_cnt = 0, v_cnt = 0 and the tick divider to 0.
REQ-022 SHALL, on reset, set every delay stage to hsync = 1, vsync = 1, blank_n = 0.
REQ-023 SHALL give priority to reset asserted mid-frame, returning the counters to (0,0) on the next edge with no frame_start pulse.
REQ-024 SHALL hold pix_tick = 0 and frame_start = 0 while reset is asserted.

Configuration
REQ-025 SHALL, with VGA_PIX_DIV2_EN defined, generate pix_tick from a 1-bit toggle: 0 on the first clock after reset, 1 on the next, and alternating thereafter (25 MHz pixel rate from a 50 MHz clock).
REQ-026 SHALL, with VGA_PIX_DIV2_EN undefined, hold pix_tick = 1 on every clock with reset = 0.

Structure
REQ-027 SHALL take from shared package vga_pkg the constants H_VISIBLE, H_FRONT, H_SYNC, H_BACK, H_TOTAL, V_VISIBLE, V_FRONT, V_SYNC, V_BACK, V_TOTAL, X_BLANK (10'h3FF) and Y_BLANK (9'h1FF).
REQ-028 SHALL implement the delay chain as sub-module vga_sync_delay, parameterised by depth, with 3-bit data and reset value 3'b110 (hsync, vsync, blank_n).

Verification
REQ-029 Bench SHALL check: reset, then 800 ticks, macro off -> x runs 0..639 then 3FF; y = 0; h_cnt wraps to 0 and y = 1 on tick 800.
REQ-030 Bench SHALL check: one full frame, SYNC_DELAY = 0 -> exactly 420000 ticks, hsync low for 96 ticks per line, vsync low for 1600 ticks, one frame_start.
REQ-031 Bench SHALL check: SYNC_DELAY = 2 -> blank_n rises exactly 2 clocks after x changes 3FF->0 at the start of line 1.
REQ-032 Bench SHALL check: VGA_PIX_DIV2_EN defined -> pix_tick pattern 0,1,0,1 after reset; a full frame takes 840000 clocks.
REQ-033 Bench SHALL check: reset pulsed at h = 700, v = 300 -> next clock has x = 0, y = 0, hsync = vsync = 1, blank_n = 0, frame_start = 0.
REQ-034 Bench SHALL check: v = 479 → 480 boundary -> y goes from 479 to 1FF and stays at 1FF until the frame wraps.
